// File: rtl/mips_pkg.sv
// Shared fetch-stage types and constants.
// Imported by the fetch FSM, its buffer and the bench.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INST     = 32'h0000_0000;

  localparam logic [0:0] FS_REQ  = 1'b0;
  localparam logic [0:0] FS_WAIT = 1'b1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Handshake bundles of the fetch stage: instruction memory
// on one side, decode on the other.
interface imem_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_gnt_i,
    input  imem_rvalid_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_gnt_i,
    output imem_rvalid_i,
    output imem_rdata_i
  );
endinterface

interface id_if;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_inst_o;
  logic [31:0] id_pc_o;

  modport master (
    output id_valid_o,
    input  id_ready_i,
    output id_inst_o,
    output id_pc_o
  );

  modport slave (
    input  id_valid_o,
    output id_ready_i,
    input  id_inst_o,
    input  id_pc_o
  );
endinterface

// File: rtl/fetch_fifo.sv
// DEPTH-entry buffer of {pc, inst} fetch entries.
// Flush beats push and pop in the same cycle.
module fetch_fifo
  import mips_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t entry_i,
  input  logic         pop_i,
  output fetch_entry_t head_o,
  output logic [AW:0]  count_o
);

  localparam logic [AW:0] FULL = DEPTH[AW:0];

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push_en;
  logic          pop_en;

  assign pop_en  = pop_i && (cnt_q != '0);
  assign push_en = push_i && ((cnt_q != FULL) || pop_en);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push_en, pop_en})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en && !flush_i) begin
      mem_q[wr_ptr_q] <= entry_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/inst_fetch.sv
// Fetch sequencer: one outstanding imem request, PC-tagged
// responses buffered for decode, redirects drop stale words.
module inst_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  imem_if.master      imem,
  id_if.master        id
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [0:0]   state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic         discard_q, discard_d;

  logic [AW:0]  count;
  fetch_entry_t head;
  fetch_entry_t entry;
  logic         in_req;
  logic         in_wait;
  logic         room;
  logic         req;
  logic         fire;
  logic         rsp;
  logic         push;
  logic         pop;
  logic         valid;

  assign in_req  = (state_q == FS_REQ);
  assign in_wait = (state_q == FS_WAIT);
  assign room    = (count < FULL_CNT);
  assign valid   = (count != '0);

  // Only request with a free slot, so every response fits.
  assign req  = in_req && room && !rst;
  assign fire = req && imem.imem_gnt_i;
  assign rsp  = in_wait && imem.imem_rvalid_i;
  assign push = rsp && !discard_q && !redirect_i;
  assign pop  = valid && id.id_ready_i;

  assign entry.pc   = fetch_pc_q - 32'd4;
  assign entry.inst = imem.imem_rdata_i;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;
    unique case (1'b1)
      in_req: begin
        if (fire) begin
          state_d    = FS_WAIT;
          fetch_pc_d = fetch_pc_q + 32'd4;
        end
      end
      in_wait: begin
        if (rsp) begin
          state_d   = FS_REQ;
          discard_d = 1'b0;
        end
      end
      default: ;
    endcase
    // A response already in flight belongs to the old path.
    if (redirect_i) begin
      fetch_pc_d = word_align(redirect_pc_i);
      discard_d  = (in_wait && !imem.imem_rvalid_i) || fire;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FS_REQ;
      fetch_pc_q <= RESET_PC;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_i),
    .push_i  (push),
    .entry_i (entry),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (count)
  );

  assign imem.imem_req_o  = req;
  assign imem.imem_addr_o = rst ? RESET_PC : fetch_pc_q;

  assign id.id_valid_o = valid;
  assign id.id_inst_o  = valid ? head.inst : NOP_INST;
  assign id.id_pc_o    = valid ? head.pc : 32'h0;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed and randomised bench for inst_fetch with a
// delay-programmable memory model and a PC scoreboard.
module tb_inst_fetch;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] rpc;

  always #5 clk = ~clk;

  imem_if m_if ();
  id_if   d_if ();
  imem_if wm_if ();
  id_if   wd_if ();

  inst_fetch #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (redirect),
    .redirect_pc_i (rpc),
    .imem          (m_if),
    .id            (d_if)
  );

  inst_fetch #(
    .RESET_PC (32'hFFFF_FFF8),
    .DEPTH    (2)
  ) dut_wrap (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (1'b0),
    .redirect_pc_i (32'h0),
    .imem          (wm_if),
    .id            (wd_if)
  );

  assign wd_if.id_ready_i = 1'b1;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(
    input logic [31:0] a
  );
    return a ^ 32'h5A5A_0013;
  endfunction

  // memory model for the main DUT
  int          gd_min, gd_max, rd_min, rd_max;
  bit          pend;
  int          rv_left, gwait;
  logic [31:0] raddr;
  logic [31:0] gnt_q [$];

  initial begin
    m_if.imem_gnt_i    = 1'b0;
    m_if.imem_rvalid_i = 1'b0;
    m_if.imem_rdata_i  = 32'h0;
    pend  = 1'b0;
    gwait = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend               = 1'b0;
        gwait              = 0;
        m_if.imem_gnt_i    = 1'b0;
        m_if.imem_rvalid_i = 1'b0;
      end else begin
        m_if.imem_rvalid_i = 1'b0;
        if (pend) begin
          rv_left--;
          if (rv_left == 0) begin
            m_if.imem_rvalid_i = 1'b1;
            m_if.imem_rdata_i  = mem_word(raddr);
          end
        end
        m_if.imem_gnt_i = 1'b0;
        if (m_if.imem_req_o && !pend) begin
          if (gwait == 0) m_if.imem_gnt_i = 1'b1;
          else gwait--;
        end
        if (m_if.imem_rvalid_i) pend = 1'b0;
        if (m_if.imem_gnt_i) begin
          pend    = 1'b1;
          raddr   = m_if.imem_addr_o;
          rv_left = $urandom_range(rd_max, rd_min);
          gwait   = $urandom_range(gd_max, gd_min);
          gnt_q.push_back(m_if.imem_addr_o);
        end
      end
    end
  end

  // always-grant, k=1 memory for the wrap instance
  bit          w_pend;
  logic [31:0] w_raddr;
  logic [31:0] w_q [$];

  initial begin
    wm_if.imem_gnt_i    = 1'b0;
    wm_if.imem_rvalid_i = 1'b0;
    wm_if.imem_rdata_i  = 32'h0;
    w_pend  = 1'b0;
    w_raddr = 32'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        w_pend              = 1'b0;
        wm_if.imem_gnt_i    = 1'b0;
        wm_if.imem_rvalid_i = 1'b0;
      end else begin
        wm_if.imem_rvalid_i = w_pend;
        wm_if.imem_rdata_i  = mem_word(w_raddr);
        w_pend              = 1'b0;
        wm_if.imem_gnt_i    = wm_if.imem_req_o;
        if (wm_if.imem_gnt_i) begin
          w_pend  = 1'b1;
          w_raddr = wm_if.imem_addr_o;
          w_q.push_back(wm_if.imem_addr_o);
        end
      end
    end
  end

  // scoreboard on the decode side
  logic [31:0] exp_pc;
  logic [31:0] hold_pc, hold_inst;
  bit          hold;
  int          pops = 0;
  logic [31:0] pop_q [$];

  initial begin
    hold = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_pc = 32'h0;
        hold   = 1'b0;
      end else begin
        if (hold) begin
          check("hold_pc", d_if.id_pc_o, hold_pc);
          check("hold_inst", d_if.id_inst_o, hold_inst);
        end
        if (d_if.id_valid_o) begin
          if (d_if.id_ready_i) begin
            check("pop_pc", d_if.id_pc_o, exp_pc);
            check("pop_inst", d_if.id_inst_o,
                  mem_word(d_if.id_pc_o));
            pop_q.push_back(d_if.id_pc_o);
            pops++;
            exp_pc = exp_pc + 32'd4;
          end
        end else begin
          check("nop_inst", d_if.id_inst_o, NOP_INST);
          check("nop_pc", d_if.id_pc_o, 32'h0);
        end
        hold = d_if.id_valid_o && !d_if.id_ready_i
               && !redirect;
        hold_pc   = d_if.id_pc_o;
        hold_inst = d_if.id_inst_o;
        if (redirect) exp_pc = rpc & 32'hFFFF_FFFC;
      end
    end
  end

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic drive();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input string tag);
    int i;
    for (i = 0; i < 40; i++) begin
      sample();
      if (m_if.imem_gnt_i === 1'b1) break;
    end
    check(tag, 32'(i < 40), 32'd1);
  endtask

  task automatic wait_gq(input int n, input string tag);
    int i;
    for (i = 0; i < 40; i++) begin
      if (gnt_q.size() >= n) break;
      sample();
    end
    check(tag, 32'(i < 40), 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    int i;
    for (i = 0; i < 40; i++) begin
      sample();
      if (d_if.id_valid_o === 1'b1) break;
    end
    check(tag, 32'(i < 40), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int first;
  int base;

  initial begin
    rst      = 1'b1;
    redirect = 1'b0;
    rpc      = 32'h0;
    d_if.id_ready_i = 1'b1;
    gd_min = 0; gd_max = 0;
    rd_min = 1; rd_max = 1;

    repeat (3) @(posedge clk);
    sample();
    check("rst_req", 32'(m_if.imem_req_o), 32'd0);
    check("rst_addr", m_if.imem_addr_o, 32'h0);
    check("rst_valid", 32'(d_if.id_valid_o), 32'd0);
    check("rst_inst", d_if.id_inst_o, 32'h0);
    check("rst_pc", d_if.id_pc_o, 32'h0);
    check("rst_waddr", wm_if.imem_addr_o, 32'hFFFF_FFF8);

    // streaming, k=1, decode always ready
    drive();
    rst   = 1'b0;
    first = 0;
    for (int i = 1; i <= 8; i++) begin
      sample();
      if (first == 0 && d_if.id_valid_o) first = i;
    end
    check("first_valid", 32'(first), 32'd3);
    wait_gq(4, "stream_grants");
    for (int i = 0; i < 4; i++) begin
      if (i < gnt_q.size())
        check("stream_addr", gnt_q[i], 32'(i * 4));
    end
    if (pop_q.size() >= 2) begin
      check("stream_pop0", pop_q[0], 32'h0);
      check("stream_pop1", pop_q[1], 32'h4);
    end
    check("wrap_grants", 32'(w_q.size() >= 4), 32'd1);
    if (w_q.size() >= 4) begin
      check("wrap_a0", w_q[0], 32'hFFFF_FFF8);
      check("wrap_a1", w_q[1], 32'hFFFF_FFFC);
      check("wrap_a2", w_q[2], 32'h0000_0000);
      check("wrap_a3", w_q[3], 32'h0000_0004);
    end

    // decode stalled: buffer fills after two grants
    drive();
    rst = 1'b1;
    d_if.id_ready_i = 1'b0;
    drive();
    gnt_q.delete();
    drive();
    rst = 1'b0;
    repeat (12) sample();
    check("stall_grants", 32'(gnt_q.size()), 32'd2);
    if (gnt_q.size() >= 2) begin
      check("stall_a0", gnt_q[0], 32'h0);
      check("stall_a1", gnt_q[1], 32'h4);
    end
    check("stall_req", 32'(m_if.imem_req_o), 32'd0);
    check("stall_valid", 32'(d_if.id_valid_o), 32'd1);
    check("stall_pc", d_if.id_pc_o, 32'h0);
    check("stall_inst", d_if.id_inst_o, mem_word(32'h0));
    gnt_q.delete();
    drive();
    d_if.id_ready_i = 1'b1;
    wait_gq(1, "resume_grant");
    if (gnt_q.size() >= 1)
      check("resume_addr", gnt_q[0], 32'h8);

    // redirect while waiting on a slow response
    rd_min = 3; rd_max = 3;
    wait_grant("wait_grant");
    drive();
    redirect = 1'b1;
    rpc      = 32'h0000_0103;
    gnt_q.delete();
    sample();
    check("wait_req", 32'(m_if.imem_req_o), 32'd0);
    check("wait_rv", 32'(m_if.imem_rvalid_i), 32'd0);
    drive();
    redirect = 1'b0;
    wait_gq(1, "wredir_grant");
    if (gnt_q.size() >= 1)
      check("wredir_addr", gnt_q[0], 32'h100);
    wait_valid("wredir_valid");
    check("wredir_pc", d_if.id_pc_o, 32'h100);

    // redirect together with rvalid
    rd_min = 1; rd_max = 1;
    wait_grant("rv_grant");
    drive();
    redirect = 1'b1;
    rpc      = 32'h0000_0300;
    sample();
    check("rv_same_cycle", 32'(m_if.imem_rvalid_i), 32'd1);
    drive();
    redirect = 1'b0;
    sample();
    check("rv_next_req", 32'(m_if.imem_req_o), 32'd1);
    check("rv_next_addr", m_if.imem_addr_o, 32'h300);
    wait_valid("rv_valid");
    check("rv_pc", d_if.id_pc_o, 32'h300);

    // redirect together with a grant
    wait_grant("g_grant");
    drive();
    drive();
    redirect = 1'b1;
    rpc      = 32'h0000_0200;
    sample();
    check("g_same_cycle", 32'(m_if.imem_gnt_i), 32'd1);
    drive();
    redirect = 1'b0;
    gnt_q.delete();
    wait_gq(1, "g_next_grant");
    if (gnt_q.size() >= 1)
      check("g_next_addr", gnt_q[0], 32'h200);
    wait_valid("g_valid");
    check("g_pc", d_if.id_pc_o, 32'h200);

    // random delays, stalls and redirects
    gd_min = 0; gd_max = 5;
    rd_min = 1; rd_max = 6;
    base = pops;
    for (int c = 0; c < 3000; c++) begin
      drive();
      d_if.id_ready_i = 1'($urandom_range(1, 0));
      redirect        = ($urandom_range(31, 0) == 0);
      rpc             = $urandom;
    end
    drive();
    redirect = 1'b0;
    d_if.id_ready_i = 1'b1;
    repeat (20) sample();
    check("rand_progress", 32'((pops - base) > 50), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch stage placed directly downstream of the PC register and upstream of decode. It owns the fetch-address sequencer and replaces a free-running `pc+4` increment with a handshaked sequencer:
- issues one instruction-memory request at a time;
- tags each returned word with its PC;
- buffers up to `DEPTH` fetched instructions for the decode stage;
- accepts branch/jump redirects and discards stale instructions.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset.
- `DEPTH`, default 2: instruction-buffer entries. Must be a power of two and at least 2.

Ports. Clock is `clk`; reset is `rst`, synchronous and active-high. All other signals are sampled on the rising edge of `clk`.
- `clk` input 1: clock.
- `rst` input 1: synchronous, active-high reset.
- `redirect_i` input 1: branch/jump taken; restart fetch at `redirect_pc_i`.
- `redirect_pc_i` input 32: redirect target. Bits [1:0] are ignored and forced to 0.
- `imem_req_o` output 1: request valid.
- `imem_addr_o` output 32: word-aligned request address.
- `imem_gnt_i` input 1: request accepted in this cycle.
- `imem_rvalid_i` input 1: read data valid. Arrives at least 1 cycle after grant.
- `imem_rdata_i` input 32: instruction word.
- `id_valid_o` output 1: buffer head is valid.
- `id_ready_i` input 1: decode accepts the head.
- `id_inst_o` output 32: head instruction. Reads `32'h0` (NOP) when `id_valid_o`=0.
- `id_pc_o` output 32: PC of the head instruction. Also feeds the PC module's architectural PC input.

## Operation
- State machine states: `REQ` and `WAIT`.
  - Reset puts the FSM in `REQ` with `fetch_pc`=`RESET_PC`, the buffer empty and `discard`=0.
- `REQ` state:
  - `imem_req_o`=1 only when buffer count < `DEPTH`.
  - `imem_addr_o`=`fetch_pc`.
  - On `imem_req_o`&`imem_gnt_i`, go to `WAIT` and set `fetch_pc`<=`fetch_pc`+4.
- `WAIT` state:
  - `imem_req_o`=0.
  - On `imem_rvalid_i`, push {`fetch_pc`-4, `imem_rdata_i`} into the buffer unless `discard`=1, then clear `discard` and return to `REQ`.
  - Holding the request back when count < `DEPTH` is false guarantees room for every outstanding response.
- Request stability: once asserted, `imem_req_o` and `imem_addr_o` stay stable until grant. The only exception is `redirect_i`, which may retarget an ungranted request in the next cycle.
- Redirect (highest priority) does all of the following in the same edge:
  - `fetch_pc`<=`{redirect_pc_i[31:2],2'b00}`;
  - buffer flushed;
  - `discard`<=1 if the FSM is in `WAIT`, or if a grant occurs in the redirect cycle. In the grant case the FSM moves to `WAIT` with `discard`=1 and `fetch_pc` still takes the redirect target, not the target+4.
- Simultaneous events:
  - Redirect with a pop: the flush wins. Decode still consumes the head in that cycle, and the flush empties everything else.
  - Redirect with `imem_rvalid_i`: the response is dropped and the FSM returns to `REQ`.
  - Push and pop in the same cycle: count is unchanged.
- Address wrap: `32'hFFFF_FFFC`+4 = `32'h0000_0000`. Modulo-2^32 arithmetic, no flag.
- Pop: occurs when `id_valid_o`&`id_ready_i`. Pointer arithmetic is modulo `DEPTH` with a (log2 `DEPTH`)+1-bit count.
- Reset mid-transaction: state is cleared. Any in-flight response arriving after reset is ignored, because the FSM is in `REQ` and only accepts `rvalid` in `WAIT`.

## Timing
- Reset values of outputs: `imem_req_o`=0 during `rst`, `imem_addr_o`=`RESET_PC`, `id_valid_o`=0, `id_inst_o`=0, `id_pc_o`=0.
- The first request is asserted in the first cycle after `rst` falls.
- Grant at cycle N with `rvalid` at N+k gives `id_valid_o` at N+k+1, because the buffer is registered.
- Steady-state throughput is one instruction per 2 cycles (k=1), as `REQ` and `WAIT` alternate.
- After a redirect at cycle R with no pending response, the request to the target is issued at R+1.
- `id_*` outputs hold stable while `id_valid_o`=1 and `id_ready_i`=0.

## Structure
- Shared package `mips_pkg` holds:
  - `RESET_PC` default;
  - `NOP_INST` = `32'h0`;
  - the fetch FSM state encoding `{REQ, WAIT}`;
  - the 64-bit fetch-entry layout {pc[63:32], inst[31:0]}.
- Sub-module `fetch_fifo`: parameterised `DEPTH` × 64-bit synchronous FIFO with push, pop, flush and count. Flush has priority over push.
- The top level holds the FSM, `fetch_pc`, `discard` and the output NOP mux.

## Test plan
- Reset release, memory always grants with k=1, `id_ready_i`=1 → `imem_addr_o` sequence 0, 4, 8, 12; `id_pc_o`/`id_inst_o` pairs match memory contents; `id_valid_o` first rises 3 cycles after reset release.
- `id_ready_i`=0 with `DEPTH`=2 → exactly 2 grants, then `imem_req_o`=0 with the buffer full and outputs stable. Raising `id_ready_i` resumes fetch at 8.
- Redirect to `32'h0000_0103` while in `WAIT` → stale response dropped, buffer flushed, next request address `32'h0000_0100`, next `id_pc_o` is `32'h100`.
- Redirect in the same cycle as a grant and the same cycle as `rvalid` (two runs) → no instruction from the old path ever appears with `id_valid_o`=1.
- `RESET_PC`=`32'hFFFF_FFF8` → addresses FFF8, FFFC, 0000_0000, 0000_0004.
- Memory with random grant delays 0–5 and `rvalid` delays 1–6, random `id_ready_i` and redirects → scoreboard: the `id_pc_o` stream is sequential between redirects, with no loss or duplication.
